// File: rtl/traffic_phase_sched.sv
// Central phase sequencer for a two-approach intersection: day ring, pedestrian truncation/service,
// emergency pre-emption and night flashing yellow. Optional all-red phases: define TRAFFIC_ALLRED_EN.
module traffic_phase_sched #(
    parameter int GREEN_T   = 20,
    parameter int FLASH_T   = 5,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 1,
    parameter int MIN_GREEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       day_night,
    input  logic [1:0] ped_req,
    input  logic [1:0] emg_req,
    output logic [5:0] light_led,
    output logic [1:0] ped_walk,
    output logic [1:0] ped_pending,
    output logic [7:0] cnt_bcd,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        G1  = 4'd0, F1 = 4'd1, Y1 = 4'd2, AR1 = 4'd3,
        G2  = 4'd4, F2 = 4'd5, Y2 = 4'd6, AR2 = 4'd7,
        EMG = 4'd8, NIGHT = 4'd9
    } state_t;

`ifdef TRAFFIC_ALLRED_EN
    localparam state_t START_STATE = AR2;
`else
    localparam state_t START_STATE = G1;
`endif

    function automatic logic [6:0] phaseLen(input state_t s);
        case (s)
            G1, G2:   phaseLen = 7'(GREEN_T);
            F1, F2:   phaseLen = 7'(FLASH_T);
            Y1, Y2:   phaseLen = 7'(YELLOW_T);
            AR1, AR2: phaseLen = 7'(ALLRED_T);
            default:  phaseLen = 7'd0;
        endcase
    endfunction

    function automatic state_t ringNext(input state_t s);
        case (s)
            G1:      ringNext = F1;
            F1:      ringNext = Y1;
`ifdef TRAFFIC_ALLRED_EN
            Y1:      ringNext = AR1;
            AR1:     ringNext = G2;
            Y2:      ringNext = AR2;
            AR2:     ringNext = G1;
`else
            Y1:      ringNext = G2;
            Y2:      ringNext = G1;
`endif
            G2:      ringNext = F2;
            F2:      ringNext = Y2;
            default: ringNext = s;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic       blink_q, blink_d;
    logic       emgDir_q, emgDir_d;
    logic [1:0] pedSync1_q, pedSync2_q, pedPrev_q;
    logic [1:0] pedPending_q, pedPending_d;
    logic [1:0] pedWalk_q, pedWalk_d;

    logic       onA1, onA2, emgAny, emgSel, ownGreen, otherGreen, truncate, clearEnd;
    logic       entering;
    logic [1:0] pedEdge, serve;

    assign onA1       = (state_q == G1) || (state_q == F1);
    assign onA2       = (state_q == G2) || (state_q == F2);
    assign emgAny     = |emg_req;
    assign emgSel     = ~emg_req[0];
    assign ownGreen   = emgSel ? onA2 : onA1;
    assign otherGreen = emgSel ? onA1 : onA2;
    assign pedEdge    = pedSync2_q & ~pedPrev_q;
    assign truncate   = ((state_q == G1 && pedPending_q[0]) || (state_q == G2 && pedPending_q[1]))
                        && (remaining_q > 7'(MIN_GREEN));

`ifdef TRAFFIC_ALLRED_EN
    assign clearEnd = (state_q == AR1) || (state_q == AR2);
`else
    assign clearEnd = (state_q == Y1) || (state_q == Y2);
`endif

    // Priority: night, night exit, held emergency, new pre-emption, pedestrian truncation, tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        emgDir_d    = emgDir_q;
        if (!day_night) begin
            state_d = NIGHT;
        end else if (state_q == NIGHT) begin
            state_d     = START_STATE;
            remaining_d = phaseLen(START_STATE);
        end else if (state_q == EMG) begin
            if (!emg_req[emgDir_q]) begin
                state_d     = emgDir_q ? F2 : F1;
                remaining_d = 7'(FLASH_T);
            end
        end else if (emgAny && ownGreen) begin
            state_d  = EMG;
            emgDir_d = emgSel;
        end else if (emgAny && otherGreen) begin
            state_d     = onA1 ? Y1 : Y2;
            remaining_d = 7'(YELLOW_T);
        end else if (truncate) begin
            remaining_d = 7'(MIN_GREEN);
        end else if (tick) begin
            if (remaining_q > 7'd1) begin
                remaining_d = remaining_q - 7'd1;
            end else if (clearEnd && emgAny) begin
                state_d  = EMG;
                emgDir_d = emgSel;
            end else begin
                state_d     = ringNext(state_q);
                remaining_d = phaseLen(ringNext(state_q));
            end
        end
    end

    always_comb begin
        entering = (state_d != state_q);
        blink_d  = tick ? ~blink_q : blink_q;
        if (entering && (state_d == F1 || state_d == F2 || state_d == NIGHT)) begin
            blink_d = 1'b1;
        end
        // A green entry serves the crossing that runs alongside it; a same-cycle edge re-arms it.
        serve[0]     = entering && (state_d == G2) && pedPending_q[0];
        serve[1]     = entering && (state_d == G1) && pedPending_q[1];
        pedPending_d = (pedPending_q & ~serve) | pedEdge;
        pedWalk_d    = entering ? serve : pedWalk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= START_STATE;
            remaining_q  <= phaseLen(START_STATE);
            blink_q      <= 1'b1;
            emgDir_q     <= 1'b0;
            pedSync1_q   <= 2'b00;
            pedSync2_q   <= 2'b00;
            pedPrev_q    <= 2'b00;
            pedPending_q <= 2'b00;
            pedWalk_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            blink_q      <= blink_d;
            emgDir_q     <= emgDir_d;
            pedSync1_q   <= ped_req;
            pedSync2_q   <= pedSync1_q;
            pedPrev_q    <= pedSync2_q;
            pedPending_q <= pedPending_d;
            pedWalk_q    <= pedWalk_d;
        end
    end

    always_comb begin
        light_led = 6'b100_100;
        case (state_q)
            G1:      light_led = 6'b001_100;
            F1:      light_led = {2'b00, blink_q, 3'b100};
            Y1:      light_led = 6'b010_100;
            G2:      light_led = 6'b100_001;
            F2:      light_led = {3'b100, 2'b00, blink_q};
            Y2:      light_led = 6'b100_010;
            EMG:     light_led = emgDir_q ? 6'b100_001 : 6'b001_100;
            NIGHT:   light_led = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
            default: light_led = 6'b100_100;
        endcase
    end

    assign cnt_bcd     = (state_q == EMG || state_q == NIGHT) ? 8'h00
                         : {4'(remaining_q / 7'd10), 4'(remaining_q % 7'd10)};
    assign phase       = state_q;
    assign ped_walk    = pedWalk_q;
    assign ped_pending = pedPending_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: directed phase walks push expected lamp, countdown
// and pedestrian values into a queue; a negedge monitor pops and compares them.
module tb_traffic_phase_sched;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       day_night;
    logic [1:0] ped_req;
    logic [1:0] emg_req;
    logic [5:0] light_led;
    logic [1:0] ped_walk;
    logic [1:0] ped_pending;
    logic [7:0] cnt_bcd;
    logic [3:0] phase;

    traffic_phase_sched dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .day_night  (day_night),
        .ped_req    (ped_req),
        .emg_req    (emg_req),
        .light_led  (light_led),
        .ped_walk   (ped_walk),
        .ped_pending(ped_pending),
        .cnt_bcd    (cnt_bcd),
        .phase      (phase)
    );

    localparam logic [5:0] G1L    = 6'b001_100;
    localparam logic [5:0] F1ON   = 6'b001_100;
    localparam logic [5:0] F1OFF  = 6'b000_100;
    localparam logic [5:0] Y1L    = 6'b010_100;
    localparam logic [5:0] ARL    = 6'b100_100;
    localparam logic [5:0] G2L    = 6'b100_001;
    localparam logic [5:0] F2ON   = 6'b100_001;
    localparam logic [5:0] Y2L    = 6'b100_010;
    localparam logic [5:0] NTON   = 6'b010_010;
    localparam logic [5:0] NTOFF  = 6'b000_000;
`ifdef TRAFFIC_ALLRED_EN
    localparam logic [5:0] RST_L   = 6'b100_100;
    localparam int         RST_CNT = 1;
`else
    localparam logic [5:0] RST_L   = 6'b001_100;
    localparam int         RST_CNT = 20;
`endif

    typedef struct {
        string      name;
        logic [5:0] light;
        logic [7:0] cnt;
        logic [1:0] walk;
        logic [1:0] pend;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        bcd = 8'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic checkOutput(input string name, input string field,
                               input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s/%s: got %h, expected %h", name, field, actual, expected);
    endtask

    task automatic expectAll(input string name, input logic [5:0] l, input logic [7:0] c,
                             input logic [1:0] w, input logic [1:0] p);
        exp_t e;
        e.name  = name;
        e.light = l;
        e.cnt   = c;
        e.walk  = w;
        e.pend  = p;
        expQ.push_back(e);
    endtask

    // One clock cycle; inputs always change 1 ns after the active edge.
    task automatic applyStimulus(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "light", {2'b00, light_led}, {2'b00, e.light});
            checkOutput(e.name, "cnt", cnt_bcd, e.cnt);
            checkOutput(e.name, "walk", {6'd0, ped_walk}, {6'd0, e.walk});
            checkOutput(e.name, "pending", {6'd0, ped_pending}, {6'd0, e.pend});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; day_night = 1'b1; ped_req = 2'b00; emg_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        expectAll("reset", RST_L, bcd(RST_CNT), 2'b00, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;

        // Day ring from reset up to the start of G2
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("ring G1 entry", G1L, bcd(20), 2'b00, 2'b00);
`endif
        for (int k = 19; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("ring G1", G1L, bcd(k), 2'b00, 2'b00);
        end
        for (int k = 5; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("ring F1", (k % 2 == 1) ? F1ON : F1OFF, bcd(k), 2'b00, 2'b00);
        end
        for (int k = 4; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("ring Y1", Y1L, bcd(k), 2'b00, 2'b00);
        end
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("ring AR1", ARL, bcd(1), 2'b00, 2'b00);
`endif
        applyStimulus(1'b1); expectAll("ring G2 entry", G2L, bcd(20), 2'b00, 2'b00);

        // Pedestrian on crossing 2 truncates G2 and is served at G1
        runTicks(5); expectAll("G2 at 15", G2L, bcd(15), 2'b00, 2'b00);
        ped_req = 2'b10;
        repeat (3) applyStimulus(1'b0);
        expectAll("ped1 latched", G2L, bcd(15), 2'b00, 2'b10);
        applyStimulus(1'b0); expectAll("ped1 truncate", G2L, bcd(5), 2'b00, 2'b10);
        ped_req = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("G2 truncated", G2L, bcd(k), 2'b00, 2'b10);
        end
        runTicks(5); expectAll("F2 end", F2ON, bcd(1), 2'b00, 2'b10);
        runTicks(4); expectAll("Y2 end", Y2L, bcd(1), 2'b00, 2'b10);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("AR2", ARL, bcd(1), 2'b00, 2'b10);
`endif
        applyStimulus(1'b1); expectAll("G1 serve ped1", G1L, bcd(20), 2'b10, 2'b00);
        for (int k = 19; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("G1 walk held", G1L, bcd(k), 2'b10, 2'b00);
        end
        applyStimulus(1'b1); expectAll("F1 walk off", F1ON, bcd(5), 2'b00, 2'b00);

        // Emergency for approach 2 while approach 1 flashes
        emg_req = 2'b10;
        applyStimulus(1'b0); expectAll("emg1 -> Y1", Y1L, bcd(4), 2'b00, 2'b00);
        runTicks(3); expectAll("Y1 clearance", Y1L, bcd(1), 2'b00, 2'b00);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("AR1 before EMG", ARL, bcd(1), 2'b00, 2'b00);
`endif
        applyStimulus(1'b1); expectAll("EMG dir1", 6'b100_001, 8'h00, 2'b00, 2'b00);
        runTicks(3); expectAll("EMG frozen", 6'b100_001, 8'h00, 2'b00, 2'b00);
        emg_req = 2'b00;
        applyStimulus(1'b0); expectAll("EMG exit F2", F2ON, bcd(5), 2'b00, 2'b00);
        runTicks(4); expectAll("F2 after EMG", F2ON, bcd(1), 2'b00, 2'b00);
        applyStimulus(1'b1); expectAll("Y2 after EMG", Y2L, bcd(4), 2'b00, 2'b00);

        // Pedestrian on crossing 1 truncates G1 and is served at G2
        runTicks(3);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1);
`endif
        applyStimulus(1'b1); expectAll("G1 after EMG", G1L, bcd(20), 2'b00, 2'b00);
        runTicks(5);
        ped_req = 2'b01;
        repeat (3) applyStimulus(1'b0);
        expectAll("ped0 latched", G1L, bcd(15), 2'b00, 2'b01);
        applyStimulus(1'b0); expectAll("ped0 truncate", G1L, bcd(5), 2'b00, 2'b01);
        ped_req = 2'b00;
        runTicks(5); expectAll("F1 pending kept", F1ON, bcd(5), 2'b00, 2'b01);
        runTicks(8); expectAll("Y1 pending kept", Y1L, bcd(1), 2'b00, 2'b01);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("AR1 pending kept", ARL, bcd(1), 2'b00, 2'b01);
`endif
        applyStimulus(1'b1); expectAll("G2 serve ped0", G2L, bcd(20), 2'b01, 2'b00);
        for (int k = 19; k >= 1; k--) begin
            applyStimulus(1'b1); expectAll("G2 walk held", G2L, bcd(k), 2'b01, 2'b00);
        end
        applyStimulus(1'b1); expectAll("F2 walk off", F2ON, bcd(5), 2'b00, 2'b00);

        // Both emergencies: approach 1 wins, approach 2 waits until it drops
        emg_req = 2'b11;
        applyStimulus(1'b0); expectAll("emg11 -> Y2", Y2L, bcd(4), 2'b00, 2'b00);
        runTicks(3);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1); expectAll("AR2 before EMG", ARL, bcd(1), 2'b00, 2'b00);
`endif
        applyStimulus(1'b1); expectAll("EMG dir0", 6'b001_100, 8'h00, 2'b00, 2'b00);
        runTicks(2); expectAll("EMG ignores bit1", 6'b001_100, 8'h00, 2'b00, 2'b00);
        emg_req = 2'b10;
        applyStimulus(1'b0); expectAll("EMG exit F1", F1ON, bcd(5), 2'b00, 2'b00);
        applyStimulus(1'b0); expectAll("bit1 pre-empts Y1", Y1L, bcd(4), 2'b00, 2'b00);
        emg_req = 2'b00;

        // Night mode, pending kept through it, day return
        runTicks(3);
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b1);
`endif
        applyStimulus(1'b1); expectAll("G2 before night", G2L, bcd(20), 2'b00, 2'b00);
        runTicks(3);
        day_night = 1'b0;
        applyStimulus(1'b0); expectAll("night entry", NTON, 8'h00, 2'b00, 2'b00);
        applyStimulus(1'b1); expectAll("night blink off", NTOFF, 8'h00, 2'b00, 2'b00);
        applyStimulus(1'b1); expectAll("night blink on", NTON, 8'h00, 2'b00, 2'b00);
        ped_req = 2'b01;
        repeat (3) applyStimulus(1'b0);
        expectAll("night ped latched", NTON, 8'h00, 2'b00, 2'b01);
        ped_req = 2'b00;
        day_night = 1'b1;
`ifdef TRAFFIC_ALLRED_EN
        applyStimulus(1'b0); expectAll("night exit AR2", ARL, bcd(1), 2'b00, 2'b01);
        applyStimulus(1'b1); expectAll("G1 after night", G1L, bcd(20), 2'b00, 2'b01);
`else
        applyStimulus(1'b0); expectAll("night exit G1", G1L, bcd(20), 2'b00, 2'b01);
`endif
        applyStimulus(1'b0); expectAll("night ped truncate", G1L, bcd(5), 2'b00, 2'b01);

        // Asynchronous reset in the middle of a flashing phase
        runTicks(5); expectAll("F1 before reset", F1ON, bcd(5), 2'b00, 2'b01);
        runTicks(2);
        #1 rst = 1'b1;
        #1 expectAll("async reset", RST_L, bcd(RST_CNT), 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
